// File: rtl/teller_dispatch.sv
// ---------------------------------------------------------------------------
// teller_dispatch
//
// Sequencer between the queue people counter and the bank tellers. Whenever
// the queue is non-empty and an open teller is free, it picks a teller
// round-robin, calls it and pulses a dequeue into the counter. It tracks
// per-teller busy state, flags stuck service and counts customers served.
//
// Ports
//   clk            in   1          single clock, rising edge
//   rst_n          in   1          asynchronous, active-low reset
//   Tellers_count  in   2          open tellers; teller i enabled iff i < Tellers_count
//   teller_done    in   N_TELLERS  1-cycle pulse: teller i finished its customer
//   q_empty        in   1          empty flag from the people counter
//   deq            out  1          1-cycle dequeue pulse to the counter
//   call           out  N_TELLERS  one-hot 1-cycle call, coincident with deq
//   busy           out  N_TELLERS  teller i is serving a customer
//   svc_timeout    out  N_TELLERS  teller i busy for >= MAX_SVC cycles
//   served_cnt     out  8          customers dispatched since reset (wraps)
//   dbg_state      out  2          current FSM state (IDLE=0, DISPATCH=1, SETTLE=2)
//
// Handshake: deq/call form a fire-and-forget pulse. The counter and tellers
// have no ready signal; a pulse is a completed transfer in the cycle it is
// high. The SETTLE cycle after each dispatch gives the counter one cycle to
// update q_empty before the next decision is taken.
// ---------------------------------------------------------------------------
module teller_dispatch #(
  parameter int N_TELLERS = 3,
  parameter int SVC_W     = 6,
  parameter int MAX_SVC   = 50
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           Tellers_count,
  input  logic [N_TELLERS-1:0] teller_done,
  input  logic                 q_empty,
  output logic                 deq,
  output logic [N_TELLERS-1:0] call,
  output logic [N_TELLERS-1:0] busy,
  output logic [N_TELLERS-1:0] svc_timeout,
  output logic [7:0]           served_cnt,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    SETTLE   = 2'd2
  } state_t;

  state_t               state;
  logic [1:0]           grant_r;
  logic [1:0]           last_grant;
  logic [N_TELLERS-1:0] free;
  logic [1:0]           next_grant;
  logic                 found;
  logic [2:0]           cand;
  logic [SVC_W-1:0]     timer [N_TELLERS];

  assign dbg_state = state;

  // A teller is eligible when it is open and not already serving.
  always_comb begin
    free = '0;
    for (int i = 0; i < N_TELLERS; i++) begin
      free[i] = (2'(i) < Tellers_count) && !busy[i];
    end
  end

  // Round-robin search starting just after the last granted teller.
  always_comb begin
    next_grant = '0;
    found      = 1'b0;
    cand       = '0;
    for (int k = 1; k <= N_TELLERS; k++) begin
      cand = {1'b0, last_grant} + 3'(k);
      if (cand >= 3'(N_TELLERS)) cand = cand - 3'(N_TELLERS);
      for (int j = 0; j < N_TELLERS; j++) begin
        if (!found && cand == 3'(j) && free[j]) begin
          found      = 1'b1;
          next_grant = 2'(j);
        end
      end
    end
  end

  // Sequencer FSM. deq/call are registered so they are high exactly while
  // the FSM sits in DISPATCH; an async reset drops them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_r    <= '0;
      last_grant <= 2'(N_TELLERS - 1);
      deq        <= 1'b0;
      call       <= '0;
      served_cnt <= '0;
    end else begin
      deq  <= 1'b0;
      call <= '0;
      case (state)
        IDLE: begin
          if (!q_empty && found) begin
            grant_r <= next_grant;
            deq     <= 1'b1;
            call    <= {{(N_TELLERS-1){1'b0}}, 1'b1} << next_grant;
            state   <= DISPATCH;
          end
        end
        DISPATCH: begin
          last_grant <= grant_r;
          served_cnt <= served_cnt + 8'd1;
          state      <= SETTLE;
        end
        SETTLE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Per-teller busy flag and service timer. A grant in DISPATCH wins over a
  // done pulse for the same teller; otherwise done clears busy and timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      for (int i = 0; i < N_TELLERS; i++) timer[i] <= '0;
    end else begin
      for (int i = 0; i < N_TELLERS; i++) begin
        if (state == DISPATCH && grant_r == 2'(i)) begin
          busy[i] <= 1'b1;
        end else if (teller_done[i]) begin
          busy[i] <= 1'b0;
        end

        if (teller_done[i] && !(state == DISPATCH && grant_r == 2'(i))) begin
          timer[i] <= '0;
        end else if (busy[i] && timer[i] != SVC_W'(MAX_SVC)) begin
          timer[i] <= timer[i] + 1'b1;
        end
      end
    end
  end

  // Timer saturates at MAX_SVC, so the flag holds until done or reset.
  always_comb begin
    svc_timeout = '0;
    for (int i = 0; i < N_TELLERS; i++) begin
      svc_timeout[i] = (timer[i] == SVC_W'(MAX_SVC));
    end
  end

endmodule

// File: tb/tb_teller_dispatch.sv
module tb_teller_dispatch;

  localparam int N = 3;

  logic         clk;
  logic         rst_n;
  logic [1:0]   Tellers_count;
  logic [N-1:0] teller_done;
  logic         q_empty;
  logic         deq;
  logic [N-1:0] call;
  logic [N-1:0] busy;
  logic [N-1:0] svc_timeout;
  logic [7:0]   served_cnt;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [N-1:0] exp_q[$];

  teller_dispatch #(.N_TELLERS(N), .SVC_W(6), .MAX_SVC(50)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .Tellers_count (Tellers_count),
    .teller_done   (teller_done),
    .q_empty       (q_empty),
    .deq           (deq),
    .call          (call),
    .busy          (busy),
    .svc_timeout   (svc_timeout),
    .served_cnt    (served_cnt),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Waits for the next negedge with deq high; n = negedges waited.
  task automatic wait_deq(input int bound, input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (deq !== 1'b1 && n < bound);
    check(name, {31'd0, deq === 1'b1}, 32'd1);
  endtask

  task automatic pulse_done(input logic [N-1:0] d);
    teller_done = d;
    tick();
    teller_done = '0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (deq === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL deq_unexpected: call=%b with no expected dispatch", call);
        end else begin
          check("call_onehot", {29'd0, call}, {29'd0, exp_q.pop_front()});
        end
      end else if (call !== '0) begin
        n_checks++;
        $display("FAIL call_without_deq: call=%b expected 000", call);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n         = 1'b0;
    q_empty       = 1'b1;
    Tellers_count = 2'd3;
    teller_done   = '0;
    repeat (3) tick();
    rst_n = 1'b1;

    // 1: reset state and quiet queue
    check("rst_deq",    {31'd0, deq}, 32'd0);
    check("rst_call",   {29'd0, call}, 32'd0);
    check("rst_busy",   {29'd0, busy}, 32'd0);
    check("rst_served", {24'd0, served_cnt}, 32'd0);
    check("rst_state",  {30'd0, dbg_state}, 32'd0);
    repeat (20) tick();
    check("idle_busy",   {29'd0, busy}, 32'd0);
    check("idle_served", {24'd0, served_cnt}, 32'd0);

    // 2: round-robin fill of three tellers at 3-cycle spacing
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b100);
    q_empty = 1'b0;
    wait_deq(10, "t2_deq0", n);
    check("t2_lat0", n, 1);
    wait_deq(10, "t2_deq1", n);
    check("t2_gap1", n, 3);
    wait_deq(10, "t2_deq2", n);
    check("t2_gap2", n, 3);
    repeat (10) tick();
    check("t2_busy",   {29'd0, busy}, 32'h7);
    check("t2_served", {24'd0, served_cnt}, 32'd3);

    // 3: teller 1 finishes and is recalled
    exp_q.push_back(3'b010);
    pulse_done(3'b010);
    check("t3_busy_cleared", {29'd0, busy}, 32'h5);
    wait_deq(10, "t3_deq", n);
    check("t3_lat", n, 1);
    repeat (4) tick();
    check("t3_served", {24'd0, served_cnt}, 32'd4);
    check("t3_busy",   {29'd0, busy}, 32'h7);

    // 4: only teller 0 open
    Tellers_count = 2'd1;
    exp_q.push_back(3'b001);
    pulse_done(3'b111);
    wait_deq(10, "t4_deq0", n);
    repeat (4) tick();
    check("t4_busy0", {29'd0, busy}, 32'h1);
    exp_q.push_back(3'b001);
    pulse_done(3'b001);
    wait_deq(10, "t4_deq1", n);
    check("t4_served", {24'd0, served_cnt}, 32'd5);

    // 5: service timeout on teller 0 (busy rises the edge after this negedge)
    repeat (50) tick();
    check("t5_timeout_before", {29'd0, svc_timeout}, 32'h0);
    tick();
    check("t5_timeout_at50", {29'd0, svc_timeout}, 32'h1);
    repeat (9) tick();
    check("t5_timeout_held", {29'd0, svc_timeout}, 32'h1);
    exp_q.push_back(3'b001);
    pulse_done(3'b001);
    check("t5_timeout_clr", {29'd0, svc_timeout}, 32'h0);
    check("t5_busy_clr",    {29'd0, busy}, 32'h0);
    wait_deq(10, "t5_regrant", n);

    // 6: reset during DISPATCH
    Tellers_count = 2'd3;
    exp_q.push_back(3'b010);
    wait_deq(10, "t6_deq", n);
    #1 rst_n = 1'b0;
    #1;
    check("t6_deq_drop",  {31'd0, deq}, 32'd0);
    check("t6_call_drop", {29'd0, call}, 32'd0);
    check("t6_served",    {24'd0, served_cnt}, 32'd0);
    check("t6_busy",      {29'd0, busy}, 32'd0);
    tick();
    q_empty = 1'b1;
    rst_n   = 1'b1;
    repeat (3) tick();
    check("t6_served_after", {24'd0, served_cnt}, 32'd0);
    check("t6_busy_after",   {29'd0, busy}, 32'd0);

    // 7: served_cnt wraps after 256 dispatches
    Tellers_count = 2'd1;
    q_empty       = 1'b0;
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(3'b001);
      wait_deq(10, "t7_deq", n);
      tick();
      if (i == 254) check("t7_served_255", {24'd0, served_cnt}, 32'd255);
      teller_done = 3'b001;
      tick();
      teller_done = '0;
      if (i == 255) q_empty = 1'b1;
    end
    repeat (5) tick();
    check("t7_served_wrap", {24'd0, served_cnt}, 32'd0);
    check("t7_busy",        {29'd0, busy}, 32'd0);
    check("exp_q_drained",  exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
